// File: rtl/m_unit_iter.sv
// m_unit_iter: iterative RISC-V M-extension multiply/divide unit.
// Works on operand magnitudes, one bit per cycle: shift-add for multiply,
// restoring division for divide. The sign is applied in FINISH.
// Divide-by-zero and signed overflow are resolved when the request is
// accepted and skip the iteration phase.
module m_unit_iter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             ABORT,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             DONE
);

  // Step counter must be able to hold WIDTH.
  localparam int              CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   COUNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  // Controller states.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  // RISC-V funct3 encodings.
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  // State registers and their next values.
  logic [1:0]       state_reg,   state_next;
  logic [CW-1:0]    count_reg,   count_next;
  logic [2:0]       op_reg,      op_next;
  logic             neg_reg,     neg_next;
  logic             special_reg, special_next;
  logic [WIDTH-1:0] hi_reg,      hi_next;
  logic [WIDTH-1:0] lo_reg,      lo_next;
  logic [WIDTH-1:0] opnd_reg,    opnd_next;
  logic [WIDTH-1:0] result_reg,  result_next;
  logic             done_reg,    done_next;

  // Request decode, only meaningful while idle.
  logic             signed1_in;
  logic             signed2_in;
  logic             s1_in;
  logic             s2_in;
  logic [WIDTH-1:0] mag1_in;
  logic [WIDTH-1:0] mag2_in;
  logic             div_zero_in;
  logic             div_ovf_in;
  logic             special_in;
  logic [WIDTH-1:0] special_val_in;
  logic             neg_in;

  // Iteration datapath.
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  // Result formation.
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_signed;
  logic [WIDTH-1:0]   div_pick;
  logic [WIDTH-1:0]   div_signed;
  logic [WIDTH-1:0]   final_result;

  // Decode signedness, magnitudes and early-resolved divide corner cases.
  always_comb begin
    signed1_in = (SELECT == OP_MUL) || (SELECT == OP_MULH) || (SELECT == OP_MULHSU) ||
                 (SELECT == OP_DIV) || (SELECT == OP_REM);
    signed2_in = (SELECT == OP_MUL) || (SELECT == OP_MULH) ||
                 (SELECT == OP_DIV) || (SELECT == OP_REM);
    s1_in      = signed1_in & DATA1[WIDTH-1];
    s2_in      = signed2_in & DATA2[WIDTH-1];
    // Negating the most negative value yields the same bit pattern, which is
    // exactly its magnitude when read as unsigned.
    mag1_in    = s1_in ? -DATA1 : DATA1;
    mag2_in    = s2_in ? -DATA2 : DATA2;
    div_zero_in = SELECT[2] && (DATA2 == '0);
    div_ovf_in  = SELECT[2] && !SELECT[0] && (DATA1 == MIN_NEG) && (DATA2 == '1);
    special_in  = div_zero_in || div_ovf_in;
    if (div_zero_in) begin
      special_val_in = SELECT[1] ? DATA1 : '1;
    end else begin
      special_val_in = SELECT[1] ? '0 : DATA1;
    end
    // Remainder takes the dividend's sign; everything else takes s1 xor s2.
    neg_in = (SELECT[2] && SELECT[1]) ? s1_in : (s1_in ^ s2_in);
  end

  // Multiplicand gated by the current multiplier LSB.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_addend
      assign addend[gi] = opnd_reg[gi] & lo_reg[0];
    end
  endgenerate

  // One shift-add or one restoring-division step.
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + {1'b0, addend};
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_reg});
    // When div_ge holds the true difference is below the divisor, so the low
    // WIDTH bits of the subtraction are exact.
    div_sub   = div_shift[WIDTH-1:0] - opnd_reg;
    if (op_reg[2]) begin
      step_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
      step_lo = {lo_reg[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  // Sign correction and selection of the architectural result.
  always_comb begin
    product        = {hi_reg, lo_reg};
    product_signed = neg_reg ? -product : product;
    div_pick       = op_reg[1] ? hi_reg : lo_reg;
    div_signed     = neg_reg ? -div_pick : div_pick;
    if (special_reg) begin
      final_result = lo_reg;
    end else if (op_reg[2]) begin
      final_result = div_signed;
    end else if (op_reg[1:0] == 2'b00) begin
      final_result = product_signed[WIDTH-1:0];
    end else begin
      final_result = product_signed[2*WIDTH-1:WIDTH];
    end
  end

  // Controller: accept, iterate, finish; abort returns to idle silently.
  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    op_next      = op_reg;
    neg_next     = neg_reg;
    special_next = special_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    opnd_next    = opnd_reg;
    result_next  = result_reg;
    done_next    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (START && !ABORT) begin
          op_next      = SELECT;
          neg_next     = neg_in;
          special_next = special_in;
          count_next   = '0;
          hi_next      = '0;
          if (special_in) begin
            lo_next    = special_val_in;
            opnd_next  = '0;
            state_next = S_FINISH;
          end else if (SELECT[2]) begin
            // Dividend shifts out of lo while quotient bits shift in.
            lo_next    = mag1_in;
            opnd_next  = mag2_in;
            state_next = S_CALC;
          end else begin
            // Multiplier shifts out of lo while product bits shift in.
            lo_next    = mag2_in;
            opnd_next  = mag1_in;
            state_next = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (ABORT) begin
          state_next = S_IDLE;
        end else begin
          hi_next    = step_hi;
          lo_next    = step_lo;
          count_next = count_reg + COUNT_ONE;
          if (count_reg == LAST_STEP) begin
            state_next = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        state_next = S_IDLE;
        if (!ABORT) begin
          result_next = final_result;
          done_next   = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State update with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= S_IDLE;
      count_reg   <= '0;
      op_reg      <= '0;
      neg_reg     <= 1'b0;
      special_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      opnd_reg    <= '0;
      result_reg  <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      op_reg      <= op_next;
      neg_reg     <= neg_next;
      special_reg <= special_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      opnd_reg    <= opnd_next;
      result_reg  <= result_next;
      done_reg    <= done_next;
    end
  end

  assign RESULT = result_reg;
  assign DONE   = done_reg;
  assign BUSY   = (state_reg != S_IDLE);

endmodule
